// File: rtl/alu_exec_stage.sv
// Two-stage ALU issue/result stage: 8x16 register file, S2->S1 forwarding, external combinational ALU.
// Optional macro ALU_EXEC_IMM_EN: the S1 immediate may replace the rs2 operand on alu_b.
module alu_exec_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic [N-1:0] in_imm,
  input  logic         in_imm_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [2:0]   out_rd,
  output logic         flag_eq,
  output logic         flag_lt
);
  localparam logic [3:0] OP_CMP = 4'd6;

  typedef struct packed {
    logic [3:0]   op;
    logic [2:0]   rd;
    logic [2:0]   rs1;
    logic [2:0]   rs2;
    logic [N-1:0] imm;
    logic         imm_sel;
  } s1_t;

  typedef struct packed {
    logic [N-1:0] data;
    logic [2:0]   rd;
    logic         is_cmp;
  } s2_t;

  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [7:0][N-1:0] rf_q, rf_d;
  logic              flag_eq_q, flag_eq_d, flag_lt_q, flag_lt_d;
  logic              s2_ld, accept, wb;
  logic [N-1:0]      rs1_val, rs2_val;

  assign s2_ld    = !vld_pipe_q[2] || out_ready;
  assign in_ready = !vld_pipe_q[1] || s2_ld;
  assign accept   = in_valid && in_ready;
  assign wb       = vld_pipe_q[2] && out_ready;

  // S2 holds the newest value of its rd; it overrides the (older) register file entry.
  always_comb begin
    rs1_val = rf_q[s1_q.rs1];
    rs2_val = rf_q[s1_q.rs2];
    if (vld_pipe_q[2] && s2_q.rd != 3'd0 && s2_q.rd == s1_q.rs1) rs1_val = s2_q.data;
    if (vld_pipe_q[2] && s2_q.rd != 3'd0 && s2_q.rd == s1_q.rs2) rs2_val = s2_q.data;
  end

  assign alu_op = s1_q.op;
  assign alu_a  = rs1_val;
`ifdef ALU_EXEC_IMM_EN
  assign alu_b  = s1_q.imm_sel ? s1_q.imm : rs2_val;
`else
  logic unused_imm;
  assign unused_imm = ^{s1_q.imm, s1_q.imm_sel};
  assign alu_b      = rs2_val;
`endif

  always_comb begin
    s1_d       = s1_q;
    s2_d       = s2_q;
    vld_pipe_d = vld_pipe_q;
    rf_d       = rf_q;
    flag_eq_d  = flag_eq_q;
    flag_lt_d  = flag_lt_q;
    if (accept) s1_d = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         imm: in_imm, imm_sel: in_imm_sel};
    vld_pipe_d[1] = accept || (vld_pipe_q[1] && !s2_ld);
    if (s2_ld) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) s2_d = '{data: alu_y, rd: s1_q.rd, is_cmp: s1_q.op == OP_CMP};
    end
    // r0 is never written, so rf_q[0] stays at its reset value of zero.
    if (wb) begin
      if (s2_q.rd != 3'd0) rf_d[s2_q.rd] = s2_q.data;
      if (s2_q.is_cmp) begin
        flag_eq_d = s2_q.data[N-1];
        flag_lt_d = s2_q.data[N-2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      vld_pipe_q <= '0;
      rf_q       <= '0;
      flag_eq_q  <= 1'b0;
      flag_lt_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      vld_pipe_q <= vld_pipe_d;
      rf_q       <= rf_d;
      flag_eq_q  <= flag_eq_d;
      flag_lt_q  <= flag_lt_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_data  = s2_q.data;
  assign out_rd    = s2_q.rd;
  assign flag_eq   = flag_eq_q;
  assign flag_lt   = flag_lt_q;
endmodule
